mvm_stream_sched: RTL and testbench
===================================

MVM_STREAM_SCHED -- requirements
Module: mvm_stream_sched

Interface
REQ-001 Parameter INW, default 16, data width of all stream beats.
REQ-002 Parameter M, default 4, result beats produced by the engine per packet.
REQ-003 Parameter N, default 4, vector length; LOGN = $clog2(N), local.
REQ-004 Parameter DEPTH, default 4, ownership FIFO entries (power of 2).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-006 S0_INPUT_TDATA/S1_INPUT_TDATA  in  INW  requester 0/1 data.
REQ-007 S0_INPUT_TVALID/S1_INPUT_TVALID  in  1;  S0_INPUT_TLAST/S1_INPUT_TLAST  in  1;  S0_INPUT_TUSER/S1_INPUT_TUSER  in  LOGN+1.
REQ-008 S0_INPUT_TREADY/S1_INPUT_TREADY  out  1  requester backpressure.
REQ-009 INPUT_TDATA  out  INW;  INPUT_TVALID  out  1;  INPUT_TLAST  out  1;  INPUT_TUSER  out  LOGN+1;  INPUT_TREADY  in  1  (engine input stream).
REQ-010 OUTPUT_TDATA  in  INW;  OUTPUT_TVALID  in  1;  OUTPUT_TREADY  out  1  (engine result stream).
REQ-011 R0_OUTPUT_TDATA/R1_OUTPUT_TDATA  out  INW;  R0_OUTPUT_TVALID/R1_OUTPUT_TVALID  out  1;  R0_OUTPUT_TREADY/R1_OUTPUT_TREADY  in  1  (per-requester results).
REQ-012 GRANT  out  2  one-hot current input owner, 00 when idle;  PKT_CNT0/PKT_CNT1  out  16  completed-packet counts.

Function
REQ-013 Packet = all beats up to and including the handshaked beat with TLAST=1; each packet yields exactly M result beats from the engine, in packet order.
REQ-014 FSM states IDLE, GRANT0, GRANT1; IDLE->GRANTx when Sx_INPUT_TVALID=1 and ownership FIFO not full; GRANTx->IDLE on handshake (INPUT_TVALID & INPUT_TREADY) of a beat with TLAST=1.
REQ-015 Round robin: both valid in IDLE -> grant the requester not granted last; after reset S0 has priority.
REQ-016 Grant latency: exactly 1 cycle from TVALID seen in IDLE to GRANTx; IDLE always lasts at least 1 cycle between packets.
REQ-017 In GRANTx: INPUT_TDATA/TVALID/TLAST/TUSER = Sx_* combinationally; Sx_INPUT_TREADY = INPUT_TREADY; other requester's TREADY = 0; in IDLE INPUT_TVALID=0 and both TREADY=0.
REQ-018 Requester ID is pushed into the ownership FIFO on the IDLE->GRANTx transition; FIFO full blocks all grants.
REQ-019 Result routing: FIFO non-empty -> head ID h: Rh_OUTPUT_TDATA/TVALID = OUTPUT_TDATA/TVALID, OUTPUT_TREADY = Rh_OUTPUT_TREADY; other R*_TVALID = 0; FIFO empty -> OUTPUT_TREADY=0, both R*_TVALID=0.
REQ-020 Result counter 0..M-1 increments per result handshake; on the M-th handshake it wraps to 0 and pops the FIFO.
REQ-021 Simultaneous push and pop in one cycle: occupancy unchanged, both take effect; push allowed when full only if a pop occurs in the same cycle.
REQ-022 R*_OUTPUT_TDATA SHALL be 0 when the corresponding TVALID is 0.
REQ-023 TVALID dropping mid-packet SHALL keep the grant (no switch until TLAST).

Reset
REQ-024 reset sampled high at a clk edge: state IDLE, priority to S0, FIFO empty, result counter 0, PKT_CNT0/1 = 0, GRANT = 00.
REQ-025 During and immediately after reset: all TREADY and TVALID outputs 0; reset mid-packet or mid-result discards all ownership (engine reset by the same signal).

Configuration
REQ-026 Macro MVM_SCHED_PERF_EN defined: PKT_CNTx increments (wrapping at 16 bits) on each TLAST handshake while GRANTx; undefined: PKT_CNT0/1 tied to 0 and no counter logic.

Verification
REQ-027 S0 sends 4-beat packet (1,2,3,4, TLAST on 4th), engine stub returns 30,70,110,150 -> all four on R0, GRANT=01 then 00, R1_TVALID stays 0.
REQ-028 S0 and S1 valid same cycle after reset -> S0 granted first, S1 granted after S0's TLAST handshake plus 1 IDLE cycle; results steered R0 then R1.
REQ-029 S1 alone sends 5 back-to-back packets with engine outputs withheld, DEPTH=4 -> 4 grants, 5th waits (S1_INPUT_TREADY=0) until first M results pop.
REQ-030 INPUT_TREADY=0 for 3 cycles mid-packet -> S0_INPUT_TREADY=0 those cycles, no beat lost or duplicated, grant held.
REQ-031 Reset asserted on 2nd result beat -> next cycle all outputs 0, FIFO empty, new S1 packet granted cleanly with results on R1.
REQ-032 With MVM_SCHED_PERF_EN: 3 S0 and 2 S1 packets -> PKT_CNT0=3, PKT_CNT1=2; without: both remain 0.

Source files
------------

// File: rtl/mvm_stream_sched.sv
// mvm_stream_sched: two-requester scheduler in front of a matrix-vector engine.
// Grants one requester's packet at a time onto the engine input stream (round
// robin), remembers packet ownership in a small FIFO, and steers the M result
// beats of each packet back to the requester that sent it.
// Optional feature macro: MVM_SCHED_PERF_EN (per-requester completed-packet counters).
module mvm_stream_sched #(
  parameter int INW   = 16,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 4,
  localparam int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [INW-1:0]  S0_INPUT_TDATA,
  input  logic            S0_INPUT_TVALID,
  input  logic            S0_INPUT_TLAST,
  input  logic [LOGN:0]   S0_INPUT_TUSER,
  output logic            S0_INPUT_TREADY,
  input  logic [INW-1:0]  S1_INPUT_TDATA,
  input  logic            S1_INPUT_TVALID,
  input  logic            S1_INPUT_TLAST,
  input  logic [LOGN:0]   S1_INPUT_TUSER,
  output logic            S1_INPUT_TREADY,
  output logic [INW-1:0]  INPUT_TDATA,
  output logic            INPUT_TVALID,
  output logic            INPUT_TLAST,
  output logic [LOGN:0]   INPUT_TUSER,
  input  logic            INPUT_TREADY,
  input  logic [INW-1:0]  OUTPUT_TDATA,
  input  logic            OUTPUT_TVALID,
  output logic            OUTPUT_TREADY,
  output logic [INW-1:0]  R0_OUTPUT_TDATA,
  output logic            R0_OUTPUT_TVALID,
  input  logic            R0_OUTPUT_TREADY,
  output logic [INW-1:0]  R1_OUTPUT_TDATA,
  output logic            R1_OUTPUT_TVALID,
  input  logic            R1_OUTPUT_TREADY,
  output logic [1:0]      GRANT,
  output logic [15:0]     PKT_CNT0,
  output logic [15:0]     PKT_CNT1
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state;
  logic             prio1;      // 1: S1 wins a tie in IDLE
  logic [DEPTH-1:0] owner;      // ownership FIFO storage (requester IDs)
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [CW-1:0]    res_cnt;

  logic fifo_empty, fifo_full, head;
  logic last_hs, res_hs, pop, push, pick1;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign head       = owner[rd_ptr];

  assign last_hs = INPUT_TVALID & INPUT_TREADY & INPUT_TLAST;
  assign res_hs  = OUTPUT_TVALID & OUTPUT_TREADY;
  assign pop     = res_hs && (res_cnt == CW'(M - 1));
  assign pick1   = S1_INPUT_TVALID && (!S0_INPUT_TVALID || prio1);
  // A full FIFO still accepts a new owner when its head retires in the same cycle.
  assign push    = (state == IDLE) && (S0_INPUT_TVALID || S1_INPUT_TVALID)
                   && (!fifo_full || pop);

  // Input mux: forward the granted requester, hold everything quiet otherwise.
  always_comb begin
    INPUT_TDATA     = '0;
    INPUT_TVALID    = 1'b0;
    INPUT_TLAST     = 1'b0;
    INPUT_TUSER     = '0;
    S0_INPUT_TREADY = 1'b0;
    S1_INPUT_TREADY = 1'b0;
    if (!reset) begin
      case (state)
        GRANT0: begin
          INPUT_TDATA     = S0_INPUT_TDATA;
          INPUT_TVALID    = S0_INPUT_TVALID;
          INPUT_TLAST     = S0_INPUT_TLAST;
          INPUT_TUSER     = S0_INPUT_TUSER;
          S0_INPUT_TREADY = INPUT_TREADY;
        end
        GRANT1: begin
          INPUT_TDATA     = S1_INPUT_TDATA;
          INPUT_TVALID    = S1_INPUT_TVALID;
          INPUT_TLAST     = S1_INPUT_TLAST;
          INPUT_TUSER     = S1_INPUT_TUSER;
          S1_INPUT_TREADY = INPUT_TREADY;
        end
        default: ;
      endcase
    end
  end

  // Result demux: steer engine results to the owner at the FIFO head.
  always_comb begin
    R0_OUTPUT_TDATA  = '0;
    R0_OUTPUT_TVALID = 1'b0;
    R1_OUTPUT_TDATA  = '0;
    R1_OUTPUT_TVALID = 1'b0;
    OUTPUT_TREADY    = 1'b0;
    if (!reset && !fifo_empty) begin
      if (head) begin
        R1_OUTPUT_TVALID = OUTPUT_TVALID;
        R1_OUTPUT_TDATA  = OUTPUT_TVALID ? OUTPUT_TDATA : '0;
        OUTPUT_TREADY    = R1_OUTPUT_TREADY;
      end else begin
        R0_OUTPUT_TVALID = OUTPUT_TVALID;
        R0_OUTPUT_TDATA  = OUTPUT_TVALID ? OUTPUT_TDATA : '0;
        OUTPUT_TREADY    = R0_OUTPUT_TREADY;
      end
    end
  end

  // Grant FSM with round-robin priority and registered GRANT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio1 <= 1'b0;
      GRANT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            state <= pick1 ? GRANT1 : GRANT0;
            GRANT <= pick1 ? 2'b10 : 2'b01;
            prio1 <= !pick1;
          end
        end
        GRANT0, GRANT1: begin
          if (last_hs) begin
            state <= IDLE;
            GRANT <= '0;
          end
        end
        default: begin
          state <= IDLE;
          GRANT <= '0;
        end
      endcase
    end
  end

  // Ownership FIFO and per-packet result counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      res_cnt <= '0;
    end else begin
      if (push) begin
        owner[wr_ptr] <= pick1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (res_hs) res_cnt <= pop ? '0 : res_cnt + 1'b1;
    end
  end

`ifdef MVM_SCHED_PERF_EN
  // Completed-packet counters, one per requester, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      PKT_CNT0 <= '0;
      PKT_CNT1 <= '0;
    end else if (last_hs) begin
      if (state == GRANT0) PKT_CNT0 <= PKT_CNT0 + 16'd1;
      if (state == GRANT1) PKT_CNT1 <= PKT_CNT1 + 16'd1;
    end
  end
`else
  assign PKT_CNT0 = '0;
  assign PKT_CNT1 = '0;
`endif

endmodule

// File: tb/tb_mvm_stream_sched.sv
// tb_mvm_stream_sched: scoreboard bench for mvm_stream_sched. Requester drivers
// pull beats from per-requester queues, an engine stub computes M results per
// forwarded packet, and a monitor compares each delivered result against the
// per-requester expectation derived from the packets as issued.
module tb_mvm_stream_sched;

  localparam int INW   = 16;
  localparam int M     = 4;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int LOGN  = $clog2(N);
`ifdef MVM_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [INW-1:0] data;
    logic           last;
    logic [LOGN:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] s_rdy;
  logic [INW-1:0] in_data;
  logic in_valid, in_last, in_ready;
  logic [LOGN:0] in_user;
  logic [INW-1:0] out_data;
  logic out_valid, out_ready;
  logic [INW-1:0] r0_data, r1_data;
  logic [1:0] r_valid, r_rdy;
  logic [1:0] grant;
  logic [15:0] pkt0, pkt1;

  bit gap_rand, itr_rand, itr_val, rr_rand, out_rand, hold_out;
  bit itr_rnd;
  logic [1:0] rr_rnd;

  int unsigned checks = 0, errors = 0;
  int unsigned cyc = 0, rhs0 = 0, rhs1 = 0, g1cnt = 0, exp_pkt0 = 0, exp_pkt1 = 0;
  logic [INW-1:0] exp0[$], exp1[$];
  logic [1:0] glog_val[$];
  int unsigned glog_cyc[$];

  assign in_ready = itr_rand ? itr_rnd : itr_val;
  assign r_rdy    = rr_rand ? rr_rnd : 2'b11;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out or unexpected event", name);
  endtask

  // Engine behaviour: result k = sum_i d[i]*(k*N+i+1) + user of last beat.
  function automatic logic [INW-1:0] mvm_res(input int unsigned k, input logic [INW-1:0] d[$],
                                             input logic [LOGN:0] u);
    int unsigned s = 0;
    for (int i = 0; i < d.size(); i++) s += 32'(d[i]) * (k * N + 32'(i) + 1);
    return INW'(s + 32'(u));
  endfunction

  // Requester drivers; each pops beats from its own queue.
  for (genvar g = 0; g < 2; g++) begin : drv
    beat_t q[$];
    logic [INW-1:0] d;
    logic v, l;
    logic [LOGN:0] u;
    initial begin
      beat_t b;
      bit hs;
      int unsigned t;
      d = '0; v = 1'b0; l = 1'b0; u = '0;
      forever begin
        @(posedge clk); #2;
        while (q.size() != 0) begin
          b = q.pop_front();
          if (gap_rand) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
          d = b.data; l = b.last; u = b.user; v = 1'b1;
          t = 0; hs = 1'b0;
          while (!hs) begin
            @(negedge clk); hs = s_rdy[g];
            @(posedge clk); #2;
            t++;
            if (!hs && t > 1000) begin
              fail_msg("driver_handshake");
              hs = 1'b1;
            end
          end
          v = 1'b0; d = '0; l = 1'b0; u = '0;
        end
      end
    end
  end

  mvm_stream_sched #(.INW(INW), .M(M), .N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .S0_INPUT_TDATA(drv[0].d), .S0_INPUT_TVALID(drv[0].v), .S0_INPUT_TLAST(drv[0].l),
    .S0_INPUT_TUSER(drv[0].u), .S0_INPUT_TREADY(s_rdy[0]),
    .S1_INPUT_TDATA(drv[1].d), .S1_INPUT_TVALID(drv[1].v), .S1_INPUT_TLAST(drv[1].l),
    .S1_INPUT_TUSER(drv[1].u), .S1_INPUT_TREADY(s_rdy[1]),
    .INPUT_TDATA(in_data), .INPUT_TVALID(in_valid), .INPUT_TLAST(in_last),
    .INPUT_TUSER(in_user), .INPUT_TREADY(in_ready),
    .OUTPUT_TDATA(out_data), .OUTPUT_TVALID(out_valid), .OUTPUT_TREADY(out_ready),
    .R0_OUTPUT_TDATA(r0_data), .R0_OUTPUT_TVALID(r_valid[0]), .R0_OUTPUT_TREADY(r_rdy[0]),
    .R1_OUTPUT_TDATA(r1_data), .R1_OUTPUT_TVALID(r_valid[1]), .R1_OUTPUT_TREADY(r_rdy[1]),
    .GRANT(grant), .PKT_CNT0(pkt0), .PKT_CNT1(pkt1)
  );

  // Engine stub: collects forwarded packets and emits M results for each.
  initial begin
    logic [INW-1:0] acc[$];
    logic [INW-1:0] eq[$];
    bit ihs, ohs, rst;
    logic [INW-1:0] ib;
    logic il;
    logic [LOGN:0] iu;
    out_valid = 1'b0; out_data = '0; itr_rnd = 1'b1; rr_rnd = 2'b11;
    forever begin
      @(negedge clk);
      ihs = in_valid & in_ready; ib = in_data; il = in_last; iu = in_user;
      ohs = out_valid & out_ready;
      @(posedge clk);
      rst = reset;
      #1;
      if (rst) begin
        acc.delete(); eq.delete(); out_valid = 1'b0;
      end else begin
        if (ohs) begin
          void'(eq.pop_front());
          out_valid = 1'b0;
        end
        if (ihs) begin
          acc.push_back(ib);
          if (il) begin
            for (int unsigned k = 0; k < M; k++) eq.push_back(mvm_res(k, acc, iu));
            acc.delete();
          end
        end
        if (!out_valid && eq.size() != 0 && !hold_out && (!out_rand || $urandom_range(0, 3) != 0))
          out_valid = 1'b1;
      end
      out_data = out_valid ? eq[0] : '0;
      itr_rnd  = ($urandom_range(0, 3) != 0);
      rr_rnd   = 2'($urandom);
    end
  end

  // Monitor: pops the expected queue on every result handshake.
  initial begin
    logic [INW-1:0] rd, e;
    string nm;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("r_valid_exclusive", {31'd0, &r_valid}, 0);
        for (int i = 0; i < 2; i++) begin
          rd = (i == 0) ? r0_data : r1_data;
          if (!r_valid[i]) begin
            nm = (i == 0) ? "r0_idle_data" : "r1_idle_data";
            check(nm, rd, 0);
          end else if (r_rdy[i]) begin
            nm = (i == 0) ? "r0_result" : "r1_result";
            if (i == 0) rhs0++; else rhs1++;
            if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) fail_msg(nm);
            else begin
              e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
              check(nm, rd, e);
            end
          end
        end
      end
    end
  end

  // Grant logger: records every change of GRANT with its cycle number.
  initial begin
    logic [1:0] gprev = 2'b00;
    forever begin
      @(negedge clk);
      if (grant != gprev) begin
        glog_val.push_back(grant);
        glog_cyc.push_back(cyc);
        if (grant == 2'b10) g1cnt++;
      end
      gprev = grant;
    end
  end

  task automatic issue(input int unsigned id, input logic [INW-1:0] pd[$],
                       input logic [LOGN:0] u, input bit model);
    beat_t b;
    for (int i = 0; i < pd.size(); i++) begin
      b.data = pd[i]; b.last = (i == pd.size() - 1); b.user = u;
      if (id == 0) drv[0].q.push_back(b); else drv[1].q.push_back(b);
    end
    if (model)
      for (int unsigned k = 0; k < M; k++)
        if (id == 0) exp0.push_back(mvm_res(k, pd, u)); else exp1.push_back(mvm_res(k, pd, u));
    if (id == 0) exp_pkt0++; else exp_pkt1++;
  endtask

  task automatic issue_rand(input int unsigned id, input int unsigned len);
    logic [INW-1:0] pd[$];
    repeat (len) pd.push_back(INW'($urandom_range(0, 255)));
    issue(id, pd, (LOGN+1)'($urandom), 1'b1);
  endtask

  task automatic wait_grant(input string name, input logic [1:0] g);
    int unsigned t = 0;
    do begin @(posedge clk); #1; t++; end while (grant != g && t < 200);
    check(name, grant, g);
  endtask

  task automatic wait_drain(input string name, input int unsigned limit);
    int unsigned t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < limit) begin
      @(posedge clk); #1; t++;
    end
    check(name, exp0.size() + exp1.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: holds reset over one edge and flushes all expectations.
  task automatic assert_reset();
    reset = 1'b1;
    exp0.delete(); exp1.delete(); drv[0].q.delete(); drv[1].q.delete();
    exp_pkt0 = 0; exp_pkt1 = 0;
    @(negedge clk);
    check("in_reset_s_rdy", s_rdy, 0);
    check("in_reset_in_valid", in_valid, 0);
    check("in_reset_r_valid", r_valid, 0);
    check("in_reset_out_ready", out_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    assert_reset();
  endtask

  task automatic check_quiet(input string tag);
    @(negedge clk);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_s_rdy"}, s_rdy, 0);
    check({tag, "_in_valid"}, in_valid, 0);
    check({tag, "_out_ready"}, out_ready, 0);
    check({tag, "_r_valid"}, r_valid, 0);
  endtask

  initial begin
    logic [INW-1:0] pd[$];
    int unsigned c0, base;
    reset = 1'b1;
    gap_rand = 0; itr_rand = 0; itr_val = 1; rr_rand = 0; out_rand = 0; hold_out = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_quiet("after_reset");
    check("after_reset_pkt0", pkt0, 0);
    check("after_reset_pkt1", pkt1, 0);

    // Single S0 packet 1,2,3,4 -> 30,70,110,150 on R0.
    pd = '{16'd1, 16'd2, 16'd3, 16'd4};
    issue(0, pd, '0, 1'b0);
    exp0.push_back(16'd30); exp0.push_back(16'd70);
    exp0.push_back(16'd110); exp0.push_back(16'd150);
    wait_grant("t027_grant", 2'b01);
    wait_drain("t027_drain", 500);
    check("t027_grant_idle", grant, 0);

    // Simultaneous requests after reset: S0 first, one IDLE cycle, then S1.
    do_reset();
    glog_val.delete(); glog_cyc.delete();
    issue_rand(0, 2);
    issue_rand(1, 2);
    c0 = cyc;
    wait_drain("t028_drain", 500);
    check("t028_glog_len", {31'd0, glog_val.size() >= 3}, 1);
    if (glog_val.size() >= 3) begin
      check("t028_first_grant", glog_val[0], 2'b01);
      check("t028_idle_gap", glog_val[1], 2'b00);
      check("t028_second_grant", glog_val[2], 2'b10);
      check("t028_grant_latency", glog_cyc[0] - c0, 1);
      check("t028_idle_cycles", glog_cyc[2] - glog_cyc[1], 1);
    end

    // Engine input stalled for 3 cycles mid-packet.
    issue_rand(0, 4);
    wait_grant("t030_grant", 2'b01);
    @(posedge clk); #1;
    itr_val = 0;
    repeat (3) begin
      @(negedge clk);
      check("t030_s0_ready_low", s_rdy[0], 0);
      check("t030_grant_held", grant, 2'b01);
      @(posedge clk); #1;
    end
    itr_val = 1;
    wait_drain("t030_drain", 500);

    // Ownership FIFO full: 5th S1 packet waits until the first results retire.
    do_reset();
    @(negedge clk);
    hold_out = 1;
    base = g1cnt;
    repeat (5) issue_rand(1, 2);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("t029_grants_while_full", g1cnt - base, 4);
    check("t029_s1_valid", drv[1].v, 1);
    check("t029_s1_ready_low", s_rdy[1], 0);
    check("t029_idle", grant, 0);
    hold_out = 0;
    wait_drain("t029_drain", 1000);
    check("t029_all_granted", g1cnt - base, 5);

    // Randomized traffic from both requesters.
    @(negedge clk);
    gap_rand = 1; itr_rand = 1; rr_rand = 1; out_rand = 1;
    repeat (40) issue_rand($urandom_range(0, 1), $urandom_range(1, N));
    wait_drain("random_drain", 20000);

    // Reset on the second result beat, then a clean S1 packet.
    @(negedge clk);
    gap_rand = 0; itr_rand = 0; rr_rand = 0; out_rand = 0;
    base = rhs0;
    issue_rand(0, 4);
    c0 = 0;
    do begin @(posedge clk); #1; c0++; end while (rhs0 == base && c0 < 500);
    check("t031_first_result", rhs0 - base, 1);
    assert_reset();
    check_quiet("t031_after_reset");
    base = rhs1;
    issue_rand(1, 3);
    wait_grant("t031_s1_grant", 2'b10);
    wait_drain("t031_drain", 500);
    check("t031_r1_beats", rhs1 - base, M);

    // Packet counters: 3 S0 and 2 S1 packets.
    do_reset();
    @(negedge clk);
    gap_rand = 1; itr_rand = 1; rr_rand = 1; out_rand = 1;
    repeat (3) issue_rand(0, $urandom_range(1, N));
    repeat (2) issue_rand(1, $urandom_range(1, N));
    wait_drain("t032_drain", 2000);
    check("t032_pkt_cnt0", pkt0, PERF ? 3 : 0);
    check("t032_pkt_cnt1", pkt1, PERF ? 2 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
